round_sequencer: RTL and testbench

- Game-round controller that sequences one `countdown_timer` instance through a fixed number of timed rounds.
- Drives the timer's active-high `reset` and `enable`, and consumes its `end_reached`.
- Accumulates player hits into a saturating score and flags game over.
- Sits between the top-level input debouncers and the timer/display datapath.

---
 rtl/round_sequencer_if.sv | 30 +++
 rtl/round_sequencer.sv | 108 ++++++++++
 tb/tb_round_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// Bundle of control pulses, timer handshake and display outputs for round_sequencer.
// The master side drives the pulse inputs and timer_end; the slave side is the sequencer.
interface round_sequencer_if #(
   parameter int NUM_ROUNDS = 5,
   parameter int SCORE_W    = 8
);
   localparam int RW = $clog2(NUM_ROUNDS + 1);

   logic               start;
   logic               pause;
   logic               hit;
   logic               timer_end;
   logic               timer_reset;
   logic               timer_enable;
   logic [RW-1:0]      round;
   logic [SCORE_W-1:0] score;
   logic               running;
   logic               game_over;
   logic [SCORE_W-1:0] high_score;

   modport master (
      output start, pause, hit, timer_end,
      input  timer_reset, timer_enable, round, score, running, game_over, high_score
   );

   modport slave (
      input  start, pause, hit, timer_end,
      output timer_reset, timer_enable, round, score, running, game_over, high_score
   );
endinterface

// File: rtl/round_sequencer.sv
// Game-round controller: sequences a countdown timer through NUM_ROUNDS rounds and keeps a saturating score.
// Optional best-game tracking is enabled by defining HIGH_SCORE_EN; otherwise high_score is tied to 0.
module round_sequencer #(
   parameter int NUM_ROUNDS = 5,
   parameter int SCORE_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   round_sequencer_if.slave bus
);
   localparam int RW = $clog2(NUM_ROUNDS + 1);
   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_PAUSED,
      S_ROUND_END,
      S_DONE
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [RW-1:0]      round_q;
   logic [SCORE_W-1:0] score_q;
   logic [SCORE_W-1:0] score_inc_d;
   logic               timer_reset_q;
   logic               timer_enable_q;
   logic               running_q;
   logic               game_over_q;
   logic               last_round;
   logic               begin_game;

   assign last_round  = (round_q == LAST_ROUND);
   assign begin_game  = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;
   assign score_inc_d = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);

   // timer_end outranks pause so a round can never be lost to a simultaneous pause
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (bus.start) state_d = S_LOAD;
         S_LOAD:      state_d = S_RUN;
         S_RUN: begin
            if (bus.timer_end)  state_d = S_ROUND_END;
            else if (bus.pause) state_d = S_PAUSED;
         end
         S_PAUSED:    if (bus.pause) state_d = S_RUN;
         S_ROUND_END: state_d = last_round ? S_DONE : S_LOAD;
         S_DONE:      if (bus.start) state_d = S_LOAD;
         default:     state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         round_q        <= '0;
         score_q        <= '0;
         timer_reset_q  <= 1'b1;
         timer_enable_q <= 1'b0;
         running_q      <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_reset_q  <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DONE);
         timer_enable_q <= (state_d == S_RUN);
         running_q      <= (state_d == S_RUN);
         game_over_q    <= (state_d == S_DONE);

         if (begin_game) begin
            round_q <= '0;
            score_q <= '0;
         end else begin
            if ((state_q == S_RUN) && bus.hit)
               score_q <= score_inc_d;
            if ((state_q == S_ROUND_END) && !last_round)
               round_q <= round_q + RW'(1);
         end
      end
   end

`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_score_q;

   // Score is frozen in ROUND_END, so the final value is compared on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_score_q <= '0;
      end else if ((state_q == S_ROUND_END) && last_round && (score_q > high_score_q)) begin
         high_score_q <= score_q;
      end
   end

   assign bus.high_score = high_score_q;
`else
   assign bus.high_score = '0;
`endif

   assign bus.timer_reset  = timer_reset_q;
   assign bus.timer_enable = timer_enable_q;
   assign bus.round        = round_q;
   assign bus.score        = score_q;
   assign bus.running      = running_q;
   assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: reset, full 5-round game, pause/hit, priority, saturation, high score.
module tb_round_sequencer;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

`ifdef HIGH_SCORE_EN
   localparam logic [7:0] HS_GAME1 = 8'd7;
`else
   localparam logic [7:0] HS_GAME1 = 8'd0;
`endif

   round_sequencer_if #(.NUM_ROUNDS(5), .SCORE_W(8)) bif ();
   round_sequencer_if #(.NUM_ROUNDS(5), .SCORE_W(2)) sif ();

   round_sequencer #(.NUM_ROUNDS(5), .SCORE_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   round_sequencer #(.NUM_ROUNDS(5), .SCORE_W(2)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
      bif.start = 0; bif.pause = 0; bif.hit = 0; bif.timer_end = 0;
      sif.start = 0; sif.pause = 0; sif.hit = 0; sif.timer_end = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) cyc();
      checks++;
      if ({bif.timer_reset, bif.timer_enable, bif.running, bif.game_over} !== 4'b1000 ||
          bif.round !== 3'd0 || bif.score !== 8'd0 || bif.high_score !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: tr=%b en=%b run=%b go=%b round=%0d score=%0d hs=%0d, want 1 0 0 0 0 0 0",
                  bif.timer_reset, bif.timer_enable, bif.running, bif.game_over, bif.round, bif.score, bif.high_score);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            bif.hit = 1; bif.pause = 1; bif.timer_end = 1;
         end
         cyc();
         checks++;
         if ({bif.timer_reset, bif.timer_enable, bif.running, bif.game_over} !== 4'b1000 ||
             bif.round !== 3'd0 || bif.score !== 8'd0) begin
            errors++;
            $display("FAIL idle_hold[%0d]: tr=%b en=%b run=%b go=%b round=%0d score=%0d, want 1 0 0 0 0 0",
                     i, bif.timer_reset, bif.timer_enable, bif.running, bif.game_over, bif.round, bif.score);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_full_game();
      int   loads;
      logic bad;
      loads = 0;
      bif.start = 1;
      cyc();
      checks++;
      if (bif.timer_reset !== 1'b1 || bif.timer_enable !== 1'b0) begin
         errors++;
         $display("FAIL load_state: tr=%b en=%b, want 1 0", bif.timer_reset, bif.timer_enable);
      end
      if (bif.timer_reset === 1'b1 && bif.game_over === 1'b0) loads++;
      cyc();
      checks++;
      if (bif.timer_enable !== 1'b1 || bif.running !== 1'b1) begin
         errors++;
         $display("FAIL start_latency: en=%b run=%b two cycles after start, want 1 1", bif.timer_enable, bif.running);
      end
      for (int r = 0; r < 5; r++) begin
         checks++;
         if (bif.round !== 3'(r)) begin
            errors++;
            $display("FAIL round_index: round=%0d, want %0d", bif.round, r);
         end
         bad = 1'b0;
         repeat (49) begin
            cyc();
            if (bif.timer_enable !== 1'b1) bad = 1'b1;
         end
         bif.timer_end = 1;
         cyc();
         checks++;
         if (bad !== 1'b0 || bif.timer_reset !== 1'b0 || bif.timer_enable !== 1'b0 || bif.game_over !== 1'b0) begin
            errors++;
            $display("FAIL round_end[%0d]: run_drop=%b tr=%b en=%b go=%b, want 0 0 0 0",
                     r, bad, bif.timer_reset, bif.timer_enable, bif.game_over);
         end
         cyc();
         if (bif.timer_reset === 1'b1 && bif.game_over === 1'b0) loads++;
         if (r < 4) begin
            cyc();
            checks++;
            if (bif.timer_enable !== 1'b1) begin
               errors++;
               $display("FAIL next_round_latency[%0d]: en=%b three cycles after timer_end, want 1", r, bif.timer_enable);
            end
         end
      end
      checks++;
      if (bif.game_over !== 1'b1 || bif.round !== 3'd4 || bif.timer_reset !== 1'b1 || loads != 5) begin
         errors++;
         $display("FAIL game_done: go=%b round=%0d tr=%b loads=%0d, want 1 4 1 5",
                  bif.game_over, bif.round, bif.timer_reset, loads);
      end
      bif.timer_end = 1; bif.hit = 1; bif.pause = 1;
      cyc();
      checks++;
      if (bif.game_over !== 1'b1 || bif.round !== 3'd4 || bif.score !== 8'd0 || bif.timer_enable !== 1'b0) begin
         errors++;
         $display("FAIL done_hold: go=%b round=%0d score=%0d en=%b, want 1 4 0 0",
                  bif.game_over, bif.round, bif.score, bif.timer_enable);
      end
      $display("test_full_game done: loads=%0d", loads);
   endtask

   task automatic test_pause_hits();
      bif.start = 1;
      cyc();
      checks++;
      if (bif.round !== 3'd0 || bif.score !== 8'd0 || bif.game_over !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear: round=%0d score=%0d go=%b, want 0 0 0", bif.round, bif.score, bif.game_over);
      end
      cyc();
      repeat (3) begin
         bif.hit = 1;
         cyc();
      end
      checks++;
      if (bif.score !== 8'd3) begin
         errors++;
         $display("FAIL run_hits: score=%0d, want 3", bif.score);
      end
      bif.pause = 1;
      cyc();
      checks++;
      if (bif.timer_enable !== 1'b0 || bif.timer_reset !== 1'b0 || bif.running !== 1'b0) begin
         errors++;
         $display("FAIL paused_outputs: en=%b tr=%b run=%b, want 0 0 0", bif.timer_enable, bif.timer_reset, bif.running);
      end
      for (int i = 0; i < 2; i++) begin
         bif.hit = 1;
         cyc();
         checks++;
         if (bif.timer_enable !== 1'b0 || bif.score !== 8'd3) begin
            errors++;
            $display("FAIL paused_hit[%0d]: en=%b score=%0d, want 0 3", i, bif.timer_enable, bif.score);
         end
      end
      bif.timer_end = 1;
      cyc();
      cyc();
      checks++;
      if (bif.timer_reset !== 1'b0 || bif.timer_enable !== 1'b0) begin
         errors++;
         $display("FAIL paused_timer_end: tr=%b en=%b, want 0 0", bif.timer_reset, bif.timer_enable);
      end
      bif.pause = 1;
      cyc();
      bif.hit = 1;
      cyc();
      checks++;
      if (bif.timer_enable !== 1'b1 || bif.round !== 3'd0 || bif.score !== 8'd4) begin
         errors++;
         $display("FAIL resume: en=%b round=%0d score=%0d, want 1 0 4", bif.timer_enable, bif.round, bif.score);
      end
      bif.start = 1;
      cyc();
      checks++;
      if (bif.timer_enable !== 1'b1 || bif.score !== 8'd4) begin
         errors++;
         $display("FAIL start_in_run: en=%b score=%0d, want 1 4", bif.timer_enable, bif.score);
      end
      $display("test_pause_hits done: score=%0d", bif.score);
   endtask

   task automatic test_priority();
      bif.hit = 1; bif.timer_end = 1; bif.pause = 1;
      cyc();
      checks++;
      if (bif.score !== 8'd5 || bif.timer_enable !== 1'b0 || bif.running !== 1'b0) begin
         errors++;
         $display("FAIL priority_end: score=%0d en=%b run=%b, want 5 0 0", bif.score, bif.timer_enable, bif.running);
      end
      cyc();
      checks++;
      if (bif.timer_reset !== 1'b1 || bif.round !== 3'd1) begin
         errors++;
         $display("FAIL priority_load: tr=%b round=%0d, want 1 1", bif.timer_reset, bif.round);
      end
      cyc();
      repeat (2) begin
         bif.hit = 1;
         cyc();
      end
      checks++;
      if (bif.timer_enable !== 1'b1 || bif.score !== 8'd7) begin
         errors++;
         $display("FAIL round1_hits: en=%b score=%0d, want 1 7", bif.timer_enable, bif.score);
      end
      $display("test_priority done: score=%0d round=%0d", bif.score, bif.round);
   endtask

   task automatic finish_game(input string tag);
      for (int i = 0; i < 300 && bif.game_over !== 1'b1; i++) begin
         bif.timer_end = bif.timer_enable;
         cyc();
      end
      checks++;
      if (bif.game_over !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: go=%b, want 1 within 300 cycles", tag, bif.game_over);
      end
   endtask

   task automatic test_high_score();
      finish_game("game1");
      checks++;
      if (bif.score !== 8'd7 || bif.high_score !== HS_GAME1) begin
         errors++;
         $display("FAIL game1_score: score=%0d hs=%0d, want 7 %0d", bif.score, bif.high_score, HS_GAME1);
      end
      bif.start = 1;
      cyc();
      checks++;
      if (bif.score !== 8'd0 || bif.high_score !== HS_GAME1) begin
         errors++;
         $display("FAIL hs_survives_start: score=%0d hs=%0d, want 0 %0d", bif.score, bif.high_score, HS_GAME1);
      end
      cyc();
      repeat (4) begin
         bif.hit = 1;
         cyc();
      end
      finish_game("game2");
      checks++;
      if (bif.score !== 8'd4 || bif.high_score !== HS_GAME1) begin
         errors++;
         $display("FAIL game2_score: score=%0d hs=%0d, want 4 %0d", bif.score, bif.high_score, HS_GAME1);
      end
      $display("test_high_score done: hs=%0d", bif.high_score);
   endtask

   task automatic test_reset_mid_game();
      bif.start = 1;
      cyc();
      cyc();
      bif.hit = 1;
      cyc();
      checks++;
      if (bif.timer_enable !== 1'b1 || bif.score !== 8'd1) begin
         errors++;
         $display("FAIL game3_run: en=%b score=%0d, want 1 1", bif.timer_enable, bif.score);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bif.timer_reset, bif.timer_enable, bif.running, bif.game_over} !== 4'b1000 ||
          bif.round !== 3'd0 || bif.score !== 8'd0 || bif.high_score !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: tr=%b en=%b run=%b go=%b round=%0d score=%0d hs=%0d, want 1 0 0 0 0 0 0",
                  bif.timer_reset, bif.timer_enable, bif.running, bif.game_over, bif.round, bif.score, bif.high_score);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      $display("test_reset_mid_game done");
   endtask

   task automatic test_saturate();
      logic [1:0] exp_score;
      sif.start = 1;
      cyc();
      cyc();
      for (int i = 1; i <= 6; i++) begin
         sif.hit = 1;
         cyc();
         exp_score = (i > 3) ? 2'd3 : 2'(i);
         checks++;
         if (sif.score !== exp_score) begin
            errors++;
            $display("FAIL saturate[%0d]: score=%0d, want %0d", i, sif.score, exp_score);
         end
      end
      $display("test_saturate done: score=%0d", sif.score);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bif.start = 0; bif.pause = 0; bif.hit = 0; bif.timer_end = 0;
      sif.start = 0; sif.pause = 0; sif.hit = 0; sif.timer_end = 0;
      test_reset();
      test_saturate();
      test_full_game();
      test_pause_hits();
      test_priority();
      test_high_score();
      test_reset_mid_game();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
